// File: rtl/r_exec_ctrl_if.sv
// Bus bundle for r_exec_ctrl: instruction handshake, ALU port, retirement
// report and register-file debug read.
interface r_exec_ctrl_if #(
   parameter int XLEN = 32
);
   // Handshake: a word moves on a rising edge where instr_valid && instr_ready;
   // the offerer holds instr stable while instr_valid is high and not yet accepted.
   logic            instr_valid;
   logic [31:0]     instr;
   logic            instr_ready;
   logic [2:0]      alu_op;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic            done;
   logic            illegal;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            zero_flag;
   logic [4:0]      dbg_addr;
   logic [XLEN-1:0] dbg_data;
   logic [1:0]      dbg_state;

   modport master (
      output instr_valid, instr, alu_result, alu_zero, dbg_addr,
      input  instr_ready, alu_op, alu_a, alu_b, done, illegal, wb_rd, wb_data,
             zero_flag, dbg_data, dbg_state
   );

   modport slave (
      input  instr_valid, instr, alu_result, alu_zero, dbg_addr,
      output instr_ready, alu_op, alu_a, alu_b, done, illegal, wb_rd, wb_data,
             zero_flag, dbg_data, dbg_state
   );
endinterface

// File: rtl/r_exec_ctrl.sv
// R-format execution controller: IDLE/DECODE/EXEC/WB sequencer driving an
// external ALU, with a 32-entry register file written back on retirement.
module r_exec_ctrl #(
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          rst_n,
   r_exec_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      WB     = 2'd3
   } state_t;

   state_t state, state_n;

   logic [5:0]      op_q, fn_q;
   logic [4:0]      rs_q, rt_q, rd_q;
   logic [2:0]      dec_op;
   logic            dec_legal;
   logic [XLEN-1:0] rf [32];
   logic [XLEN-1:0] a_q, b_q, wb_data_q;
   logic [2:0]      alu_op_q;
   logic            ill_q, zero_q;
   logic [4:0]      wb_rd_q;
   logic            xfer;

   assign xfer = bus.instr_valid && (state == IDLE);

   // Only opcode 0 with one of five functs is executable; everything else retires as illegal.
   always_comb begin
      dec_op    = 3'b000;
      dec_legal = 1'b0;
      if (op_q == 6'd0) begin
         dec_legal = 1'b1;
         case (fn_q)
            6'h20:   dec_op = 3'b000;
            6'h22:   dec_op = 3'b001;
            6'h24:   dec_op = 3'b010;
            6'h25:   dec_op = 3'b011;
            6'h2A:   dec_op = 3'b100;
            default: dec_legal = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.instr_valid) state_n = DECODE;
         DECODE:  state_n = dec_legal ? EXEC : WB;
         EXEC:    state_n = WB;
         WB:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         fn_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_op_q  <= '0;
         ill_q     <= 1'b0;
         wb_data_q <= '0;
         zero_q    <= 1'b0;
         wb_rd_q   <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         if (xfer) begin
            op_q <= bus.instr[31:26];
            rs_q <= bus.instr[25:21];
            rt_q <= bus.instr[20:16];
            rd_q <= bus.instr[15:11];
            fn_q <= bus.instr[5:0];
         end
         if (state == DECODE) begin
            a_q      <= rf[rs_q];
            b_q      <= rf[rt_q];
            alu_op_q <= dec_op;
            ill_q    <= !dec_legal;
         end
         if (state == EXEC) begin
            wb_data_q <= bus.alu_result;
            zero_q    <= bus.alu_zero;
         end
         // wb_rd follows the instruction only as it enters retirement.
         if (state_n == WB) wb_rd_q <= rd_q;
         if (state == WB && !ill_q && rd_q != 5'd0) rf[rd_q] <= wb_data_q;
      end
   end

   assign bus.instr_ready = (state == IDLE);
   assign bus.alu_op      = alu_op_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.done        = (state == WB);
   assign bus.illegal     = (state == WB) && ill_q;
   assign bus.wb_rd       = wb_rd_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.zero_flag   = zero_q;
   assign bus.dbg_data    = (bus.dbg_addr == 5'd0) ? '0 : rf[bus.dbg_addr];
   assign bus.dbg_state   = state;
endmodule

// File: tb/tb_r_exec_ctrl.sv
// Bench for r_exec_ctrl: reference ALU plus register-file model, with
// expected retirements queued at issue and compared when done pulses.
module tb_r_exec_ctrl;
   localparam int W = 39;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   r_exec_ctrl_if #(.XLEN(32)) bus ();

   r_exec_ctrl #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [31:0] mrf [32];
   logic [31:0] last_data = '0;
   logic        last_zero = 1'b0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_val = '0;

   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // ALU stand-in; ovr_en lets a test force a chosen result to preload registers.
   assign bus.alu_result = ovr_en ? ovr_val : alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
   assign bus.alu_zero   = (bus.alu_result == 32'd0);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outs(input string pfx);
      check_eq({pfx, "_ready"},   bus.instr_ready, 1);
      check_eq({pfx, "_done"},    bus.done, 0);
      check_eq({pfx, "_illegal"}, bus.illegal, 0);
      check_eq({pfx, "_alu_op"},  bus.alu_op, 0);
      check_eq({pfx, "_alu_a"},   bus.alu_a, 0);
      check_eq({pfx, "_alu_b"},   bus.alu_b, 0);
      check_eq({pfx, "_wb_rd"},   bus.wb_rd, 0);
      check_eq({pfx, "_wb_data"}, bus.wb_data, 0);
      check_eq({pfx, "_zero"},    bus.zero_flag, 0);
   endtask

   task automatic sweep_rf_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         bus.dbg_addr = i[4:0];
         #1;
         check_eq(tag, bus.dbg_data, 0);
      end
   endtask

   task automatic run_instr(input logic [31:0] w, input bit use_ovr, input logic [31:0] ov);
      logic [5:0]   op, fn;
      logic [4:0]   rs, rt, rd;
      logic [2:0]   eop;
      logic [31:0]  a, b, res;
      logic [W-1:0] e;
      bit           legal, seen;
      int           lat;
      op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
      legal = (op == 6'd0);
      eop = 3'b000;
      case (fn)
         6'h20:   eop = 3'b000;
         6'h22:   eop = 3'b001;
         6'h24:   eop = 3'b010;
         6'h25:   eop = 3'b011;
         6'h2A:   eop = 3'b100;
         default: legal = 1'b0;
      endcase
      if (!legal) eop = 3'b000;
      a = mrf[rs];
      b = mrf[rt];
      res = use_ovr ? ov : alu_fn(eop, a, b);
      if (legal) e = {1'b0, (res == 32'd0), rd, res};
      else       e = {1'b1, last_zero, rd, last_data};
      exp_q.push_back(e);

      ovr_en = use_ovr;
      ovr_val = ov;
      bus.dbg_addr = rd;
      bus.instr = w;
      bus.instr_valid = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (bus.instr_ready) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         check_eq("ready_timeout", 0, 1);
         bus.instr_valid = 1'b0;
         void'(exp_q.pop_back());
         return;
      end
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr = $urandom();

      seen = 1'b0;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = k;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check_eq("done_timeout", 0, 1);
         void'(exp_q.pop_front());
         ovr_en = 1'b0;
         return;
      end
      check_eq("latency", lat, legal ? 3 : 2);
      e = exp_q.pop_front();
      check_eq("illegal", bus.illegal, e[38]);
      check_eq("zero_flag", bus.zero_flag, e[37]);
      check_eq("wb_rd", bus.wb_rd, e[36:32]);
      check_eq("wb_data", bus.wb_data, e[31:0]);
      if (legal) begin
         check_eq("alu_op", bus.alu_op, eop);
         check_eq("alu_a", bus.alu_a, a);
         check_eq("alu_b", bus.alu_b, b);
      end
      check_eq("dbg_old", bus.dbg_data, mrf[rd]);
      if (legal && rd != 5'd0) mrf[rd] = res;
      if (legal) begin
         last_data = res;
         last_zero = (res == 32'd0);
      end
      @(negedge clk);
      check_eq("done_once", bus.done, 0);
      check_eq("dbg_new", bus.dbg_data, mrf[rd]);
      ovr_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic [5:0]  fn;
      logic [5:0]  legal_fn [5];
      legal_fn[0] = 6'h20; legal_fn[1] = 6'h22; legal_fn[2] = 6'h24;
      legal_fn[3] = 6'h25; legal_fn[4] = 6'h2A;
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      bus.instr_valid = 1'b0;
      bus.instr = '0;
      bus.dbg_addr = '0;

      // Reset and empty-file sweep.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_reset_outs("por");
      sweep_rf_zero("por_rf");
      @(negedge clk);

      // ADD r1 = r0 + r0, SUB r2 = r0 - r1.
      run_instr(32'h0000_0820, 1'b0, '0);
      run_instr(32'h0001_1022, 1'b0, '0);

      // Preload r3 = 5, r4 = 7, then SLT r5, r3, r4.
      run_instr(32'h0000_1820, 1'b1, 32'd5);
      run_instr(32'h0000_2020, 1'b1, 32'd7);
      run_instr(32'h0064_282A, 1'b0, '0);

      // Preload r6, then illegal funct 0x08 and illegal opcode aimed at it.
      run_instr(32'h0000_3020, 1'b1, 32'h0000_1234);
      run_instr(32'h0064_3008, 1'b0, '0);
      run_instr(32'h0464_3020, 1'b0, '0);

      // Write to r0 is discarded; rs == rt dependent chain follows.
      run_instr(32'h0060_0020, 1'b1, 32'hDEAD_BEEF);
      bus.dbg_addr = 5'd0;
      #1;
      check_eq("r0_zero", bus.dbg_data, 0);
      run_instr(32'h0063_3820, 1'b0, '0);
      run_instr(32'h00E7_3822, 1'b0, '0);

      // Randomized mix of legal and illegal words with random shamt.
      for (int n = 0; n < 24; n++) begin
         w = $urandom();
         case ($urandom_range(0, 9))
            0: w[31:26] = 6'($urandom_range(1, 63));
            1: begin
               w[31:26] = 6'd0;
               do fn = 6'($urandom_range(0, 63));
               while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
               w[5:0] = fn;
            end
            default: begin
               w[31:26] = 6'd0;
               w[5:0] = legal_fn[$urandom_range(0, 4)];
            end
         endcase
         run_instr(w, 1'($urandom_range(0, 1)), $urandom());
      end

      // Reset asserted while an ADD r7 = r3 + r4 sits in EXEC.
      run_instr(32'h0000_1820, 1'b1, 32'd5);
      run_instr(32'h0000_2020, 1'b1, 32'd7);
      ovr_en = 1'b1;
      ovr_val = 32'h0000_0055;
      bus.instr = 32'h0064_3820;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      @(posedge clk);
      #3;
      check_eq("pre_rst_alu_a", bus.alu_a, 32'd5);
      rst_n = 1'b0;
      #1;
      check_reset_outs("mid");
      for (int i = 0; i < 32; i++) mrf[i] = '0;
      last_data = '0;
      last_zero = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("mid_no_done", bus.done, 0);
      end
      ovr_en = 1'b0;
      sweep_rf_zero("mid_rf");
      @(negedge clk);
      rst_n = 1'b1;

      // First transfer at the first rising edge after release.
      run_instr(32'h0000_4020, 1'b1, 32'd9);
      run_instr(32'h0108_4820, 1'b0, '0);
      bus.dbg_addr = 5'd7;
      #1;
      check_eq("r7_discarded", bus.dbg_data, 0);
      check_eq("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
